// File: rtl/tmds_encoder_8b10b.sv
// TMDS 8b/10b encoder for one DVI/HDMI colour channel: a transition-minimising
// stage followed by a DC-balance stage. Output is registered, with a fixed two-cycle latency.
module tmds_encoder_8b10b #(
  parameter int CNT_W   = 5,
  parameter bit REVERSE = 1'b0
) (
  input  logic       ref_clk_i,
  input  logic       rst,
  input  logic       de_i,
  input  logic [1:0] ctrl_i,
  input  logic [7:0] dat_i,
  output logic       de_o,
  output logic [9:0] dat_o
);

  localparam logic [9:0] TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_11 = 10'b1010101011;
  localparam logic signed [CNT_W-1:0] TWO = CNT_W'(2);

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  logic [3:0] n1d;
  logic       use_xnor;
  logic [8:0] q_m_next;
  logic [8:0] q_m_reg;
  logic       de_reg;
  logic [1:0] ctrl_reg;

  always_comb begin
    logic acc;
    n1d         = ones8(dat_i);
    use_xnor    = (n1d > 4'd4) || ((n1d == 4'd4) && !dat_i[0]);
    q_m_next    = '0;
    acc         = dat_i[0];
    q_m_next[0] = acc;
    for (int i = 1; i < 8; i++) begin
      acc         = use_xnor ? ~(acc ^ dat_i[i]) : (acc ^ dat_i[i]);
      q_m_next[i] = acc;
    end
    q_m_next[8] = ~use_xnor;
  end

  always_ff @(posedge ref_clk_i or posedge rst) begin
    if (rst) begin
      q_m_reg  <= '0;
      de_reg   <= 1'b0;
      ctrl_reg <= 2'b00;
    end else begin
      q_m_reg  <= q_m_next;
      de_reg   <= de_i;
      ctrl_reg <= ctrl_i;
    end
  end

  logic [3:0]              n1;
  logic [3:0]              n0;
  logic signed [CNT_W-1:0] bal;
  logic signed [CNT_W-1:0] cnt_reg;
  logic signed [CNT_W-1:0] cnt_next;
  logic                    cnt_pos;
  logic                    cnt_neg;
  logic [9:0]              word_next;
  logic [9:0]              word_reg;
  logic                    de_o_reg;
  logic                    q8;

  // bal is the signed excess of ones over zeros in q_m[7:0]
  always_comb begin
    q8        = q_m_reg[8];
    n1        = ones8(q_m_reg[7:0]);
    n0        = 4'd8 - n1;
    bal       = CNT_W'(n1) - CNT_W'(n0);
    cnt_neg   = cnt_reg[CNT_W-1];
    cnt_pos   = !cnt_neg && (cnt_reg != '0);
    word_next = TOKEN_00;
    cnt_next  = '0;
    if (de_reg) begin
      if ((cnt_reg == '0) || (n1 == n0)) begin
        word_next = {~q8, q8, (q8 ? q_m_reg[7:0] : ~q_m_reg[7:0])};
        cnt_next  = q8 ? (cnt_reg + bal) : (cnt_reg - bal);
      end else if ((cnt_pos && (n1 > n0)) || (cnt_neg && (n0 > n1))) begin
        word_next = {1'b1, q8, ~q_m_reg[7:0]};
        cnt_next  = cnt_reg - bal + (q8 ? TWO : '0);
      end else begin
        word_next = {1'b0, q8, q_m_reg[7:0]};
        cnt_next  = cnt_reg + bal - (q8 ? '0 : TWO);
      end
    end else begin
      case (ctrl_reg)
        2'b00:   word_next = TOKEN_00;
        2'b01:   word_next = TOKEN_01;
        2'b10:   word_next = TOKEN_10;
        default: word_next = TOKEN_11;
      endcase
    end
  end

  always_ff @(posedge ref_clk_i or posedge rst) begin
    if (rst) begin
      word_reg <= TOKEN_00;
      de_o_reg <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      word_reg <= word_next;
      de_o_reg <= de_reg;
      cnt_reg  <= cnt_next;
    end
  end

  assign de_o = de_o_reg;

  // Bit order toward the serializer; reversal is pure wiring after the register
  for (genvar gi = 0; gi < 10; gi++) begin : g_out
    if (REVERSE) begin : g_rev
      assign dat_o[gi] = word_reg[9-gi];
    end else begin : g_fwd
      assign dat_o[gi] = word_reg[gi];
    end
  end

endmodule

// File: tb/tb_tmds_encoder_8b10b.sv
// Randomised and directed checks of the TMDS encoder against a behavioural model
// of the encoding rules, in both normal and bit-reversed output order.
module tb_tmds_encoder_8b10b;

  logic       ref_clk_i = 1'b0;
  logic       rst;
  logic       de_i;
  logic [1:0] ctrl_i;
  logic [7:0] dat_i;
  logic       de_o;
  logic [9:0] dat_o;
  logic       de_o_r;
  logic [9:0] dat_o_r;

  always #5 ref_clk_i = ~ref_clk_i;

  tmds_encoder_8b10b #(.CNT_W(5), .REVERSE(1'b0)) dut (
    .ref_clk_i(ref_clk_i), .rst(rst), .de_i(de_i), .ctrl_i(ctrl_i),
    .dat_i(dat_i), .de_o(de_o), .dat_o(dat_o)
  );

  tmds_encoder_8b10b #(.CNT_W(5), .REVERSE(1'b1)) dut_r (
    .ref_clk_i(ref_clk_i), .rst(rst), .de_i(de_i), .ctrl_i(ctrl_i),
    .dat_i(dat_i), .de_o(de_o_r), .dat_o(dat_o_r)
  );

  typedef struct {
    logic       de;
    logic [9:0] word;
    int         cnt;
    logic [7:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   model_cnt;
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [9:0] token_of(input logic [1:0] c);
    case (c)
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  function automatic logic [9:0] rev10(input logic [9:0] w);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = w[9-i];
    return r;
  endfunction

  function automatic logic [7:0] tmds_decode(input logic [9:0] w);
    logic [7:0] d;
    logic [7:0] o;
    d    = w[9] ? ~w[7:0] : w[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  function automatic int dut_cnt();
    return int'($signed(dut.cnt_reg));
  endfunction

  // Encoding rules written with plain integer arithmetic
  task automatic model_encode(input logic de, input logic [1:0] c, input logic [7:0] d,
                              output exp_t e);
    int n1d, n1, n0;
    logic xnor_mode, q8, invert;
    logic [7:0] qm;
    e.de  = de;
    e.dat = d;
    if (!de) begin
      e.word    = token_of(c);
      model_cnt = 0;
    end else begin
      n1d       = $countones(d);
      xnor_mode = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
      q8        = !xnor_mode;
      qm[0]     = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xnor_mode ? !(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      n1 = $countones(qm);
      n0 = 8 - n1;
      if (model_cnt == 0 || n1 == n0) begin
        invert    = !q8;
        model_cnt = model_cnt + (q8 ? (n1 - n0) : (n0 - n1));
      end else if ((model_cnt > 0 && n1 > n0) || (model_cnt < 0 && n0 > n1)) begin
        invert    = 1'b1;
        model_cnt = model_cnt + 2 * int'(q8) + (n0 - n1);
      end else begin
        invert    = 1'b0;
        model_cnt = model_cnt - 2 * int'(!q8) + (n1 - n0);
      end
      e.word = {invert, q8, (invert ? ~qm : qm)};
    end
    e.cnt = model_cnt;
  endtask

  task automatic model_reset();
    exp_t e;
    exp_q.delete();
    model_cnt = 0;
    e.de   = 1'b0;
    e.word = 10'h354;
    e.cnt  = 0;
    e.dat  = 8'h00;
    exp_q.push_back(e);
  endtask

  // Drives one symbol; returns the expectation for what dat_o now shows
  task automatic step(input logic de, input logic [1:0] c, input logic [7:0] d, output exp_t e);
    exp_t n;
    model_encode(de, c, d, n);
    exp_q.push_back(n);
    de_i   = de;
    ctrl_i = c;
    dat_i  = d;
    @(posedge ref_clk_i);
    @(negedge ref_clk_i);
    e = exp_q.pop_front();
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    de_i   = 1'b0;
    ctrl_i = 2'b00;
    dat_i  = 8'h00;
    @(negedge ref_clk_i);
    @(negedge ref_clk_i);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (dat_o !== 10'h354) $display("FAIL reset_dat: got %h expected 354", dat_o);
    else n_pass++;
    n_checks++;
    if (de_o !== 1'b0) $display("FAIL reset_de: got %b expected 0", de_o);
    else n_pass++;
    n_checks++;
    if (dut_cnt() != 0) $display("FAIL reset_cnt: got %0d expected 0", dut_cnt());
    else n_pass++;
    n_checks++;
    if (dat_o_r !== 10'h0AB) $display("FAIL reset_dat_rev: got %h expected 0ab", dat_o_r);
    else n_pass++;
    rst = 1'b0;
    model_reset();
    $display("test_reset: dat_o=%h de_o=%b", dat_o, de_o);
  endtask

  task automatic test_ctrl_tokens();
    exp_t e;
    logic [9:0] tok[4];
    tok = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'(i), 8'($urandom), e);
      if (i >= 1) begin
        n_checks++;
        if (dat_o !== tok[i-1]) $display("FAIL ctrl_token%0d: got %h expected %h", i - 1, dat_o, tok[i-1]);
        else n_pass++;
        n_checks++;
        if (de_o !== 1'b0) $display("FAIL ctrl_de%0d: got %b expected 0", i - 1, de_o);
        else n_pass++;
        $display("test_ctrl_tokens: ctrl=%0d dat_o=%h", i - 1, dat_o);
      end
    end
  endtask

  task automatic test_zero_run();
    exp_t e;
    logic [9:0] z_dat[4];
    int z_cnt[4];
    int k;
    z_dat = '{10'h100, 10'h3FF, 10'h100, 10'h3FF};
    z_cnt = '{-8, 2, -6, 4};
    k = 0;
    step(1'b0, 2'b00, 8'h00, e);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'b00, 8'h00, e);
      if (e.de && k < 4) begin
        n_checks++;
        if (dat_o !== z_dat[k]) $display("FAIL zero_run_dat%0d: got %h expected %h", k, dat_o, z_dat[k]);
        else n_pass++;
        n_checks++;
        if (dut_cnt() != z_cnt[k]) $display("FAIL zero_run_cnt%0d: got %0d expected %0d", k, dut_cnt(), z_cnt[k]);
        else n_pass++;
        $display("test_zero_run: sym%0d dat_o=%h cnt=%0d", k, dat_o, dut_cnt());
        k++;
      end
    end
  endtask

  task automatic test_ff_single();
    exp_t e;
    step(1'b0, 2'b00, 8'h00, e);
    step(1'b1, 2'b00, 8'hFF, e);
    step(1'b0, 2'b00, 8'h00, e);
    n_checks++;
    if (dat_o !== 10'h200) $display("FAIL ff_dat: got %h expected 200", dat_o);
    else n_pass++;
    n_checks++;
    if (dut_cnt() != -8) $display("FAIL ff_cnt: got %0d expected -8", dut_cnt());
    else n_pass++;
    $display("test_ff_single: dat_o=%h cnt=%0d", dat_o, dut_cnt());
    step(1'b0, 2'b00, 8'h00, e);
    n_checks++;
    if (dut_cnt() != 0) $display("FAIL ff_cnt_clear: got %0d expected 0", dut_cnt());
    else n_pass++;
    $display("test_ff_single: after blanking cnt=%0d", dut_cnt());
  endtask

  task automatic test_reverse();
    exp_t e;
    do_reset();
    n_checks++;
    if (dat_o_r !== 10'h0AB) $display("FAIL rev_token: got %h expected 0ab", dat_o_r);
    else n_pass++;
    rst = 1'b0;
    model_reset();
    step(1'b1, 2'b00, 8'h00, e);
    step(1'b0, 2'b00, 8'h00, e);
    n_checks++;
    if (dat_o_r !== 10'h002) $display("FAIL rev_zero: got %h expected 002", dat_o_r);
    else n_pass++;
    n_checks++;
    if (dat_o !== 10'h100) $display("FAIL fwd_zero: got %h expected 100", dat_o);
    else n_pass++;
    $display("test_reverse: dat_o_r=%h dat_o=%h", dat_o_r, dat_o);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      step(1'(i % 2), 2'($urandom), 8'($urandom), e);
      n_checks++;
      if (dat_o !== e.word) $display("FAIL b2b_dat%0d: got %h expected %h", i, dat_o, e.word);
      else n_pass++;
      n_checks++;
      if (dut_cnt() != e.cnt) $display("FAIL b2b_cnt%0d: got %0d expected %0d", i, dut_cnt(), e.cnt);
      else n_pass++;
      $display("test_back_to_back: %0d de=%b dat_o=%h cnt=%0d", i, e.de, dat_o, dut_cnt());
    end
  endtask

  task automatic test_random();
    exp_t e;
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom), e);
      n_checks++;
      if (dat_o !== e.word) $display("FAIL rnd_dat%0d: got %h expected %h", i, dat_o, e.word);
      else n_pass++;
      n_checks++;
      if (de_o !== e.de) $display("FAIL rnd_de%0d: got %b expected %b", i, de_o, e.de);
      else n_pass++;
      n_checks++;
      if (dut_cnt() != e.cnt) $display("FAIL rnd_cnt%0d: got %0d expected %0d", i, dut_cnt(), e.cnt);
      else n_pass++;
      n_checks++;
      if (dat_o_r !== rev10(e.word)) $display("FAIL rnd_rev%0d: got %h expected %h", i, dat_o_r, rev10(e.word));
      else n_pass++;
      n_checks++;
      if (dut_cnt() > 10 || dut_cnt() < -10) $display("FAIL rnd_bound%0d: got %0d expected within +-10", i, dut_cnt());
      else n_pass++;
      if (e.de) begin
        n_checks++;
        if (tmds_decode(dat_o) !== e.dat)
          $display("FAIL rnd_decode%0d: got %h expected %h", i, tmds_decode(dat_o), e.dat);
        else n_pass++;
      end
      $display("test_random: %0d de=%b in=%h dat_o=%h cnt=%0d", i, e.de, e.dat, dat_o, dut_cnt());
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    for (int i = 0; i < 6; i++) step(1'b1, 2'b00, 8'($urandom_range(1, 254)), e);
    step(1'b1, 2'b00, 8'h00, e);
    @(posedge ref_clk_i);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (dat_o !== 10'h354) $display("FAIL async_rst_dat: got %h expected 354", dat_o);
    else n_pass++;
    n_checks++;
    if (de_o !== 1'b0) $display("FAIL async_rst_de: got %b expected 0", de_o);
    else n_pass++;
    n_checks++;
    if (dut_cnt() != 0) $display("FAIL async_rst_cnt: got %0d expected 0", dut_cnt());
    else n_pass++;
    $display("test_async_reset: dat_o=%h de_o=%b cnt=%0d", dat_o, de_o, dut_cnt());
    de_i = 1'b0;
    @(negedge ref_clk_i);
    @(negedge ref_clk_i);
    rst = 1'b0;
    model_reset();
    step(1'b1, 2'b00, 8'h00, e);
    n_checks++;
    if (dat_o !== 10'h354) $display("FAIL async_rst_flush: got %h expected 354", dat_o);
    else n_pass++;
    step(1'b0, 2'b00, 8'h00, e);
    n_checks++;
    if (dat_o !== 10'h100) $display("FAIL async_rst_first: got %h expected 100", dat_o);
    else n_pass++;
    $display("test_async_reset: first symbol after reset dat_o=%h", dat_o);
  endtask

  initial begin
    rst    = 1'b1;
    de_i   = 1'b0;
    ctrl_i = 2'b00;
    dat_i  = 8'h00;
    test_reset();
    test_ctrl_tokens();
    test_zero_run();
    test_ff_single();
    test_back_to_back();
    test_random();
    test_async_reset();
    test_reverse();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
